// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap/non-overlap matching.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bit_in         : serial data bit, sampled when bit_valid=1
//   bit_valid      : qualifies bit_in
//   cfg_load       : strobe latching cfg_pattern/cfg_len/cfg_overlap
//   cfg_pattern    : pattern, bit [cfg_len-1] received first, bit [0] last
//   cfg_len        : pattern length, legal 1..MAX_LEN
//   cfg_overlap    : 1 = overlapping matches, 0 = restart after a match
//   cnt_clr        : synchronous clear of match_count
//   detected       : one-cycle pulse per match
//   match_count    : saturating match counter
//   cfg_err        : one-cycle pulse on a rejected cfg_load
//   armed          : a valid configuration is held
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    typedef enum logic {
        UNCFG,
        RUN
    } state_t;

    state_t             state;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic               legal;
    logic               accept;
    logic               match;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;

    always_comb begin
        legal    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        // A load in the same cycle always discards the bit.
        accept   = bit_valid && (state == RUN) && !cfg_load;
        shifted  = {hist[MAX_LEN-2:0], bit_in};
        // Shifting all-ones left by len leaves ones only above the pattern.
        mask     = ~({MAX_LEN{1'b1}} << len);
        fill_inc = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
        match    = accept
                && (fill_inc >= {1'b0, len})
                && (((shifted ^ pat) & mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UNCFG;
            pat         <= '0;
            len         <= '0;
            ovl         <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            detected    <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            detected <= match;
            cfg_err  <= cfg_load && !legal;

            if (cfg_load) begin
                if (legal) begin
                    state <= RUN;
                    armed <= 1'b1;
                    pat   <= cfg_pattern;
                    len   <= cfg_len;
                    ovl   <= cfg_overlap;
                    hist  <= '0;
                    fill  <= '0;
                end
            end else if (accept) begin
                if (match && !ovl) begin
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= shifted;
                    if (fill < len) begin
                        fill <= fill_inc[LEN_W-1:0];
                    end
                end
            end

            if (cnt_clr) begin
                match_count <= match ? CNT_W'(1) : '0;
            end else if (match && !(&match_count)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed table, corner
// sequences and randomized stimulus against a queue-based reference.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               bit_in;
    logic               bit_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;
    logic               armed;

    seq_detector_prog #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .detected   (detected),
        .match_count(match_count),
        .cfg_err    (cfg_err),
        .armed      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: received bits since the last restart, oldest first.
    bit             q[$];
    bit             m_run;
    bit [7:0]       m_pat;
    int             m_len;
    bit             m_ovl;
    bit             m_det;
    int             m_cnt;
    bit             m_err;

    typedef struct {
        bit       bv;
        bit       b;
        bit       ld;
        bit [7:0] pat;
        int       len;
        bit       ovl;
        bit       clr;
        bit       e_det;
        int       e_cnt;
        bit       e_err;
        bit       e_arm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit bv, bit b, bit ld, bit [7:0] pat,
                                int len, bit ovl, bit clr, bit e_det,
                                int e_cnt, bit e_err, bit e_arm);
        vec_t v;
        v.bv = bv; v.b = b; v.ld = ld; v.pat = pat; v.len = len;
        v.ovl = ovl; v.clr = clr; v.e_det = e_det; v.e_cnt = e_cnt;
        v.e_err = e_err; v.e_arm = e_arm;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0; m_pat = 0; m_len = 0; m_ovl = 0;
        m_det = 0; m_cnt = 0; m_err = 0;
    endtask

    task automatic model_step(bit bv, bit b, bit ld, bit [7:0] pat,
                              int len, bit ovl, bit clr);
        bit hit;
        hit = 0;
        m_err = 0;
        if (ld) begin
            if (len >= 1 && len <= MAX_LEN) begin
                m_run = 1; m_pat = pat; m_len = len; m_ovl = ovl;
                q.delete();
            end else begin
                m_err = 1;
            end
        end else if (bv && m_run) begin
            q.push_back(b);
            if (q.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
            end
            if (hit && !m_ovl) q.delete();
            while (q.size() > MAX_LEN) void'(q.pop_front());
        end
        m_det = hit;
        if (clr) m_cnt = hit ? 1 : 0;
        else if (hit && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".detected"}, int'(detected), int'(m_det));
        chk({tag, ".match_count"}, int'(match_count), m_cnt);
        chk({tag, ".cfg_err"}, int'(cfg_err), int'(m_err));
        chk({tag, ".armed"}, int'(armed), int'(m_run));
    endtask

    task automatic cyc(bit bv, bit b, bit ld, bit [7:0] pat, int len,
                       bit ovl, bit clr, string tag);
        bit_valid   = bv;
        bit_in      = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        cnt_clr     = clr;
        @(posedge clk);
        model_step(bv, b, ld, pat, len, ovl, clr);
        #1;
        chk_model(tag);
    endtask

    task automatic bitc(bit b, string tag);
        cyc(1, b, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic idle(string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst.detected", int'(detected), 0);
        chk("rst.match_count", int'(match_count), 0);
        chk("rst.cfg_err", int'(cfg_err), 0);
        chk("rst.armed", int'(armed), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int at;
        rst_n = 1'b0;
        bit_in = 0; bit_valid = 0; cfg_load = 0; cfg_pattern = 0;
        cfg_len = 0; cfg_overlap = 0; cnt_clr = 0;
        do_reset();

        // Directed table from reset: unconfigured, bad loads, 1011 both
        // modes, load-vs-bit collision, len=1 saturation, clr with match.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'hb, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'hb, 9, 1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'hb, 4, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'hb, 4, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 8'h1, 1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].bv, tbl[i].b, tbl[i].ld, tbl[i].pat, tbl[i].len,
                tbl[i].ovl, tbl[i].clr, "tbl");
            chk($sformatf("tbl%0d.det", i), int'(detected),
                int'(tbl[i].e_det));
            chk($sformatf("tbl%0d.cnt", i), int'(match_count),
                tbl[i].e_cnt);
            chk($sformatf("tbl%0d.err", i), int'(cfg_err),
                int'(tbl[i].e_err));
            chk($sformatf("tbl%0d.arm", i), int'(armed),
                int'(tbl[i].e_arm));
        end

        // Gapped 1011: three idle cycles between bits, one late pulse.
        do_reset();
        cyc(0, 0, 1, 8'hb, 4, 1, 0, "gap");
        pulses = 0;
        at = -1;
        for (int k = 0; k < 4; k++) begin
            bit bb;
            bb = (k == 1) ? 1'b0 : 1'b1;
            bitc(bb, "gap");
            if (detected) begin pulses++; at = k; end
            for (int g = 0; g < 3; g++) begin
                idle("gap");
                if (detected) pulses++;
            end
        end
        chk("gap.pulses", pulses, 1);
        chk("gap.pulse_pos", at, 3);
        chk("gap.count", int'(match_count), 1);

        // Reset mid-stream: history lost, pending pulse cancelled.
        do_reset();
        cyc(0, 0, 1, 8'hb, 4, 1, 0, "rmid");
        bitc(1, "rmid");
        bitc(0, "rmid");
        bitc(1, "rmid");
        do_reset();
        cyc(0, 0, 1, 8'hb, 4, 1, 0, "rmid");
        bitc(1, "rmid");
        chk("rmid.no_pulse", int'(detected), 0);
        bitc(1, "rmid");
        bitc(0, "rmid");
        bitc(1, "rmid");
        bitc(1, "rmid");
        chk("rmid.pulse", int'(detected), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid.cancel", int'(detected), 0);
        chk("rmid.cnt_clr", int'(match_count), 0);
        do_reset();

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit       ld;
            bit       clr;
            bit [7:0] pat;
            int       len;
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                ld  = ($urandom_range(0, 99) < 3) || (n == 0);
                clr = $urandom_range(0, 99) < 4;
                pat = 8'($urandom);
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9)
                                                  : $urandom_range(1, 3);
                cyc($urandom_range(0, 9) < 7, 1'($urandom), ld, pat, len,
                    1'($urandom), clr, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
